// File: rtl/axi_reg_arbiter_pkg.sv
// Shared types and constants for the AXI4-Lite register-map arbiter.
package axi_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WR   = 2'd1,
      RD   = 2'd2,
      RESP = 2'd3
   } arb_state_e;

   localparam logic [1:0]  AXI_RESP_OKAY = 2'b00;
   localparam logic [31:0] RDATA_RESET   = 32'hDEADDEAD;
   localparam logic [3:0]  WSTRB_ALL     = 4'hF;

   // Index width that stays legal for a single requester.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/axi_reg_arbiter_if.sv
// Requester-side and AXI4-Lite master signals of the arbiter, grouped in one bundle.
interface axi_reg_arbiter_if #(
   parameter int NUM_REQ    = 2,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ-1:0]            req_we;
   logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
   logic [NUM_REQ-1:0]            req_ready;
   logic [NUM_REQ-1:0]            rsp_valid;
   logic [DATA_WIDTH-1:0]         rsp_rdata;
   logic                          rsp_err;

   logic [ADDR_WIDTH-1:0] m_axi_awaddr;
   logic                  m_axi_awvalid;
   logic                  m_axi_awready;
   logic [DATA_WIDTH-1:0] m_axi_wdata;
   logic [3:0]            m_axi_wstrb;
   logic                  m_axi_wvalid;
   logic                  m_axi_wready;
   logic                  m_axi_bvalid;
   logic                  m_axi_bready;
   logic [1:0]            m_axi_bresp;
   logic [ADDR_WIDTH-1:0] m_axi_araddr;
   logic                  m_axi_arvalid;
   logic                  m_axi_arready;
   logic [DATA_WIDTH-1:0] m_axi_rdata;
   logic                  m_axi_rvalid;
   logic                  m_axi_rready;
   logic [1:0]            m_axi_rresp;

   // Arbiter side: consumes requests, drives the AXI master channels.
   modport master (
      input  req_valid, req_we, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err,
      output m_axi_awaddr, m_axi_awvalid, m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
      output m_axi_bready, m_axi_araddr, m_axi_arvalid, m_axi_rready,
      input  m_axi_awready, m_axi_wready, m_axi_bvalid, m_axi_bresp,
      input  m_axi_arready, m_axi_rdata, m_axi_rvalid, m_axi_rresp
   );

   // Environment side: requesters plus the register-map slave.
   modport slave (
      output req_valid, req_we, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err,
      input  m_axi_awaddr, m_axi_awvalid, m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
      input  m_axi_bready, m_axi_araddr, m_axi_arvalid, m_axi_rready,
      output m_axi_awready, m_axi_wready, m_axi_bvalid, m_axi_bresp,
      output m_axi_arready, m_axi_rdata, m_axi_rvalid, m_axi_rresp
   );

endinterface

// File: rtl/axi_reg_arbiter_rr_grant.sv
// Combinational round-robin picker: first set request above last_grant, with wrap-around.
module rr_grant
   import axi_arb_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = idx_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last_grant,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDX_W-1:0]   gnt_idx,
   output logic               gnt_any
);

   int             cand;
   logic [IDX_W-1:0] cand_idx;

   always_comb begin
      gnt      = '0;
      gnt_idx  = '0;
      gnt_any  = 1'b0;
      cand     = 0;
      cand_idx = '0;
      for (int off = 1; off <= NUM_REQ; off++) begin
         cand = int'(last_grant) + off;
         if (cand >= NUM_REQ) cand = cand - NUM_REQ;
         cand_idx = IDX_W'(cand);
         if (!gnt_any && req[cand_idx]) begin
            gnt_any       = 1'b1;
            gnt_idx       = cand_idx;
            gnt[cand_idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/axi_reg_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite slave between NUM_REQ single-beat requesters.
// Optional slave timeout is compiled in with `define AXI_ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for any req_valid; grants and registers the winner
// WR    | AW and W issued independently, waiting for the B handshake
// RD    | AR issued, waiting for the R handshake
// RESP  | one-cycle rsp_valid pulse to the granted requester
module axi_reg_arbiter
   import axi_arb_pkg::*;
#(
   parameter int NUM_REQ        = 2,
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input logic                clk,
   input logic                reset,
   axi_reg_arbiter_if.master  bus
);

   localparam int IDX_W = idx_width(NUM_REQ);
   localparam int TMR_W = $clog2(TIMEOUT_CYCLES) + 1;

   arb_state_e            state_q, state_d;
   logic [IDX_W-1:0]      last_grant_q, last_grant_d;
   logic [IDX_W-1:0]      gnt_idx_q, gnt_idx_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  err_q, err_d;
   logic                  aw_pend_q, aw_pend_d;
   logic                  w_pend_q, w_pend_d;
   logic                  ar_pend_q, ar_pend_d;
   logic [NUM_REQ-1:0]    req_ready_q, req_ready_d;

   logic [NUM_REQ-1:0]    pick_gnt;
   logic [IDX_W-1:0]      pick_idx;
   logic                  pick_any;
   logic                  bready, rready;
   logic                  aw_hs, w_hs, ar_hs, b_hs, r_hs;
   logic                  timeout;

   rr_grant #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_grant (
      .req        (bus.req_valid),
      .last_grant (last_grant_q),
      .gnt        (pick_gnt),
      .gnt_idx    (pick_idx),
      .gnt_any    (pick_any)
   );

   // B may complete together with the W handshake, never ahead of it.
   assign bready = (state_q == WR) && (!w_pend_q || bus.m_axi_wready);
   assign rready = (state_q == RD);
   assign aw_hs  = aw_pend_q && bus.m_axi_awready;
   assign w_hs   = w_pend_q && bus.m_axi_wready;
   assign ar_hs  = ar_pend_q && bus.m_axi_arready;
   assign b_hs   = bus.m_axi_bvalid && bready;
   assign r_hs   = bus.m_axi_rvalid && rready;

`ifdef AXI_ARB_TIMEOUT_EN
   logic [TMR_W-1:0] timer_q, timer_d;
   logic             busy;

   assign busy    = (state_q == WR) || (state_q == RD);
   assign timer_d = busy ? timer_q + TMR_W'(1) : '0;
   assign timeout = busy && (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) timer_q <= '0;
      else       timer_q <= timer_d;
   end
`else
   logic [TMR_W-1:0] unused_timer;
   assign unused_timer = '0;
   assign timeout      = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      gnt_idx_d    = gnt_idx_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      rdata_d      = rdata_q;
      err_d        = err_q;
      aw_pend_d    = aw_pend_q;
      w_pend_d     = w_pend_q;
      ar_pend_d    = ar_pend_q;
      req_ready_d  = '0;
      case (state_q)
         IDLE: begin
            if (pick_any) begin
               last_grant_d = pick_idx;
               gnt_idx_d    = pick_idx;
               addr_d       = bus.req_addr[int'(pick_idx)*ADDR_WIDTH +: ADDR_WIDTH];
               wdata_d      = bus.req_wdata[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
               req_ready_d  = pick_gnt;
               if (bus.req_we[pick_idx]) begin
                  state_d   = WR;
                  aw_pend_d = 1'b1;
                  w_pend_d  = 1'b1;
               end else begin
                  state_d   = RD;
                  ar_pend_d = 1'b1;
               end
            end
         end
         WR: begin
            if (aw_hs) aw_pend_d = 1'b0;
            if (w_hs)  w_pend_d  = 1'b0;
            if (b_hs) begin
               err_d     = (bus.m_axi_bresp != AXI_RESP_OKAY);
               aw_pend_d = 1'b0;
               w_pend_d  = 1'b0;
               state_d   = RESP;
            end else if (timeout) begin
               err_d     = 1'b1;
               rdata_d   = DATA_WIDTH'(RDATA_RESET);
               aw_pend_d = 1'b0;
               w_pend_d  = 1'b0;
               state_d   = RESP;
            end
         end
         RD: begin
            if (ar_hs) ar_pend_d = 1'b0;
            if (r_hs) begin
               rdata_d   = bus.m_axi_rdata;
               err_d     = (bus.m_axi_rresp != AXI_RESP_OKAY);
               ar_pend_d = 1'b0;
               state_d   = RESP;
            end else if (timeout) begin
               err_d     = 1'b1;
               rdata_d   = DATA_WIDTH'(RDATA_RESET);
               ar_pend_d = 1'b0;
               state_d   = RESP;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         last_grant_q <= IDX_W'(NUM_REQ - 1);
         gnt_idx_q    <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         rdata_q      <= DATA_WIDTH'(RDATA_RESET);
         err_q        <= 1'b0;
         aw_pend_q    <= 1'b0;
         w_pend_q     <= 1'b0;
         ar_pend_q    <= 1'b0;
         req_ready_q  <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         gnt_idx_q    <= gnt_idx_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         rdata_q      <= rdata_d;
         err_q        <= err_d;
         aw_pend_q    <= aw_pend_d;
         w_pend_q     <= w_pend_d;
         ar_pend_q    <= ar_pend_d;
         req_ready_q  <= req_ready_d;
      end
   end

   assign bus.req_ready     = req_ready_q;
   assign bus.rsp_valid     = (state_q == RESP) ? (NUM_REQ'(1) << gnt_idx_q) : '0;
   assign bus.rsp_rdata     = rdata_q;
   assign bus.rsp_err       = err_q;
   assign bus.m_axi_awaddr  = addr_q;
   assign bus.m_axi_awvalid = aw_pend_q;
   assign bus.m_axi_wdata   = wdata_q;
   assign bus.m_axi_wstrb   = (state_q == WR) ? WSTRB_ALL : '0;
   assign bus.m_axi_wvalid  = w_pend_q;
   assign bus.m_axi_bready  = bready;
   assign bus.m_axi_araddr  = addr_q;
   assign bus.m_axi_arvalid = ar_pend_q;
   assign bus.m_axi_rready  = rready;

endmodule

// File: tb/tb_axi_reg_arbiter.sv
// Directed bench for axi_reg_arbiter: vector table plus hand-written corner sequences.
module tb_axi_reg_arbiter;
   import axi_arb_pkg::*;

`ifdef AXI_ARB_TIMEOUT_EN
   localparam int TMO = 16;
`else
   localparam int TMO = 256;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   axi_reg_arbiter_if #(.NUM_REQ(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

   axi_reg_arbiter #(
      .NUM_REQ        (2),
      .ADDR_WIDTH     (32),
      .DATA_WIDTH     (32),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      int          idx;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      bit          exp_err;
   } vec_t;

   int n_vec = 0;
   int n_err = 0;

   bit s_no_b    = 1'b0;
   bit s_b_same  = 1'b0;
   bit s_no_ar   = 1'b0;
   int s_w_delay = 0;
   logic [31:0] mem [logic [31:0]];

   task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   task automatic bound_fail(input string nm);
      n_vec++;
      n_err++;
      $display("FAIL %s: no DUT event within cycle bound", nm);
   endtask

   // Register-map slave model: addresses below 0x1000 are mapped, others return SLVERR.
   task automatic s_write(input logic [31:0] a, input logic [31:0] d);
      if (a < 32'h1000) begin
         mem[a] = d;
         bus.m_axi_bresp = 2'b00;
      end else begin
         bus.m_axi_bresp = 2'b10;
      end
      bus.m_axi_bvalid = 1'b1;
   endtask

   initial begin : slave
      bit aw_hs, w_hs, b_hs, ar_hs, r_hs;
      bit aw_got, w_got, ar_got;
      logic [31:0] sa_aw, sa_w, sa_ar, wa, wd, ra;
      int w_wait;
      aw_got = 0; w_got = 0; ar_got = 0; w_wait = 0;
      wa = '0; wd = '0; ra = '0;
      bus.m_axi_awready = 0; bus.m_axi_wready = 0; bus.m_axi_bvalid = 0; bus.m_axi_bresp = 0;
      bus.m_axi_arready = 0; bus.m_axi_rvalid = 0; bus.m_axi_rdata = 0; bus.m_axi_rresp = 0;
      forever begin
         @(negedge clk);
         aw_hs = bus.m_axi_awvalid && bus.m_axi_awready;
         w_hs  = bus.m_axi_wvalid && bus.m_axi_wready;
         b_hs  = bus.m_axi_bvalid && bus.m_axi_bready;
         ar_hs = bus.m_axi_arvalid && bus.m_axi_arready;
         r_hs  = bus.m_axi_rvalid && bus.m_axi_rready;
         sa_aw = bus.m_axi_awaddr;
         sa_w  = bus.m_axi_wdata;
         sa_ar = bus.m_axi_araddr;
         @(posedge clk);
         #1;
         if (reset) begin
            aw_got = 0; w_got = 0; ar_got = 0; w_wait = 0;
            bus.m_axi_awready = 0; bus.m_axi_wready = 0; bus.m_axi_bvalid = 0;
            bus.m_axi_arready = 0; bus.m_axi_rvalid = 0;
         end else begin
            if (aw_hs) begin aw_got = 1; wa = sa_aw; end
            if (w_hs)  begin w_got = 1; wd = sa_w; end
            if (b_hs)  begin bus.m_axi_bvalid = 0; aw_got = 0; w_got = 0; end
            if (r_hs)  bus.m_axi_rvalid = 0;
            if (ar_hs) begin ar_got = 1; ra = sa_ar; end
            if (!s_b_same && !s_no_b && aw_got && w_got && !bus.m_axi_bvalid) s_write(wa, wd);
            if (ar_got && !bus.m_axi_rvalid) begin
               if (ra < 32'h1000) begin
                  bus.m_axi_rdata = mem.exists(ra) ? mem[ra] : 32'h0;
                  bus.m_axi_rresp = 2'b00;
               end else begin
                  bus.m_axi_rdata = 32'h0BAD0BAD;
                  bus.m_axi_rresp = 2'b10;
               end
               bus.m_axi_rvalid = 1;
               ar_got = 0;
            end
            w_wait = (bus.m_axi_wvalid && !w_got) ? w_wait + 1 : 0;
            bus.m_axi_awready = bus.m_axi_awvalid && !aw_got;
            bus.m_axi_wready  = bus.m_axi_wvalid && !w_got && (w_wait > s_w_delay);
            bus.m_axi_arready = bus.m_axi_arvalid && !ar_got && !s_no_ar;
            // Same-cycle B: respond together with the accepting W beat.
            if (s_b_same && !s_no_b && !bus.m_axi_bvalid && bus.m_axi_wready &&
                (aw_got || bus.m_axi_awready))
               s_write(aw_got ? wa : bus.m_axi_awaddr, bus.m_axi_wdata);
         end
      end
   end

   task automatic wait_grant(input string nm, output int g, output bit ok);
      ok = 0;
      g  = 0;
      for (int c = 0; c < 20 && !ok; c++) begin
         @(negedge clk);
         if (bus.req_ready != 2'b00) begin
            ok = 1;
            g  = bus.req_ready[1] ? 1 : 0;
         end
      end
      if (!ok) bound_fail({nm, "_grant"});
   endtask

   task automatic wait_rsp(input string nm, output int cyc, output bit ok);
      ok  = 0;
      cyc = 0;
      for (int c = 1; c <= 40 && !ok; c++) begin
         @(negedge clk);
         if (bus.rsp_valid != 2'b00) begin
            ok  = 1;
            cyc = c;
         end
      end
      if (!ok) bound_fail({nm, "_rsp"});
   endtask

   task automatic set_req(input int idx, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
      bus.req_we[idx]             = we;
      bus.req_addr[idx*32 +: 32]  = addr;
      bus.req_wdata[idx*32 +: 32] = wdata;
      bus.req_valid[idx]          = 1'b1;
   endtask

   task automatic finish_rsp(input string nm, input int idx, input logic [31:0] exp_rd, input bit exp_err);
      int cyc;
      bit ok;
      logic [1:0] oh;
      oh = 2'b01 << idx;
      wait_rsp(nm, cyc, ok);
      if (ok) begin
         check({nm, "_rsp_valid"}, 64'(bus.rsp_valid), 64'(oh));
         check({nm, "_rdata"}, 64'(bus.rsp_rdata), 64'(exp_rd));
         check({nm, "_err"}, 64'(bus.rsp_err), 64'(exp_err));
         @(negedge clk);
         check({nm, "_single_pulse"}, 64'(bus.rsp_valid), 64'(0));
      end
   endtask

   task automatic do_txn(input int idx, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rd, input bit exp_err, input string nm);
      int g;
      bit ok;
      logic [1:0] oh;
      oh = 2'b01 << idx;
      set_req(idx, we, addr, wdata);
      wait_grant(nm, g, ok);
      bus.req_valid[idx] = 1'b0;
      if (ok) begin
         check({nm, "_req_ready"}, 64'(bus.req_ready), 64'(oh));
         if (we) begin
            check({nm, "_aw_w_valid"}, 64'({bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_wstrb}), 64'(6'b11_1111));
            check({nm, "_awaddr_wdata"}, {bus.m_axi_awaddr, bus.m_axi_wdata}, {addr, wdata});
         end else begin
            check({nm, "_arvalid_addr"}, 64'({bus.m_axi_arvalid, bus.m_axi_araddr}), 64'({1'b1, addr}));
         end
         finish_rsp(nm, idx, exp_rd, exp_err);
      end
   endtask

   // One grant of a held-request sequence; drop_mask clears requests once granted.
   task automatic pair_grant(input int exp_idx, input logic [31:0] exp_rd, input logic [1:0] drop_mask, input string nm);
      int g;
      bit ok;
      logic [1:0] oh;
      oh = 2'b01 << exp_idx;
      wait_grant(nm, g, ok);
      bus.req_valid = bus.req_valid & ~drop_mask;
      if (ok) begin
         check({nm, "_grant"}, 64'(bus.req_ready), 64'(oh));
         finish_rsp(nm, g, exp_rd, 1'b0);
      end
   endtask

   vec_t vecs [7];

   initial begin : main
      bit seen;
      vecs[0] = '{0, 1'b1, 32'h0000_0003, 32'h1234_5678, 32'hDEAD_DEAD, 1'b0};
      vecs[1] = '{0, 1'b0, 32'h0000_0003, 32'h0,         32'h1234_5678, 1'b0};
      vecs[2] = '{1, 1'b1, 32'h0000_0010, 32'hCAFE_F00D, 32'h1234_5678, 1'b0};
      vecs[3] = '{1, 1'b0, 32'h0000_0010, 32'h0,         32'hCAFE_F00D, 1'b0};
      vecs[4] = '{0, 1'b0, 32'h0000_2000, 32'h0,         32'h0BAD_0BAD, 1'b1};
      vecs[5] = '{1, 1'b1, 32'h0000_2004, 32'h0000_0001, 32'h0BAD_0BAD, 1'b1};
      vecs[6] = '{1, 1'b0, 32'h0000_0003, 32'h0,         32'h1234_5678, 1'b0};

      bus.req_valid = '0;
      bus.req_we    = '0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;

      repeat (3) @(negedge clk);
      check("rst_req_ready", 64'(bus.req_ready), 64'(0));
      check("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
      check("rst_axi_vr", 64'({bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_arvalid,
                               bus.m_axi_bready, bus.m_axi_rready}), 64'(0));
      check("rst_rdata_err", 64'({bus.rsp_rdata, bus.rsp_err}), 64'({32'hDEAD_DEAD, 1'b0}));
      check("rst_addr_data", {bus.m_axi_awaddr, bus.m_axi_wdata}, 64'(0));
      reset = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 7; i++)
         do_txn(vecs[i].idx, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                vecs[i].exp_rdata, vecs[i].exp_err, $sformatf("vec%0d", i));

      // Both requesters hold reads; grants must alternate 0,1,0,1.
      set_req(0, 1'b0, 32'h0000_0003, 32'h0);
      set_req(1, 1'b0, 32'h0000_0010, 32'h0);
      for (int k = 0; k < 4; k++)
         pair_grant(k % 2, (k % 2 == 0) ? 32'h1234_5678 : 32'hCAFE_F00D,
                    (k == 3) ? 2'b11 : 2'b00, $sformatf("rot%0d", k));

      // B arrives in the same cycle as a delayed W handshake.
      s_b_same  = 1'b1;
      s_w_delay = 2;
      do_txn(0, 1'b1, 32'h0000_0020, 32'h55AA_55AA, 32'hCAFE_F00D, 1'b0, "bsame_wr");
      seen = 1'b0;
      repeat (3) begin
         @(negedge clk);
         seen = seen | (|bus.rsp_valid);
      end
      check("bsame_no_extra_rsp", 64'(seen), 64'(0));
      s_b_same  = 1'b0;
      s_w_delay = 0;
      do_txn(0, 1'b0, 32'h0000_0020, 32'h0, 32'h55AA_55AA, 1'b0, "bsame_rdback");

      // Reset while the write waits for B.
      s_no_b = 1'b1;
      begin
         int g;
         bit ok;
         set_req(0, 1'b1, 32'h0000_0030, 32'h0000_0077);
         wait_grant("rstwr", g, ok);
         bus.req_valid = 2'b00;
      end
      repeat (3) @(negedge clk);
      check("rstwr_pending_bready", 64'({bus.m_axi_bready, bus.rsp_valid}), 64'({1'b1, 2'b00}));
      reset = 1'b1;
      @(negedge clk);
      check("rstwr_req_rsp", 64'({bus.req_ready, bus.rsp_valid}), 64'(0));
      check("rstwr_axi_vr", 64'({bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_arvalid,
                                 bus.m_axi_bready, bus.m_axi_rready}), 64'(0));
      check("rstwr_rdata_err", 64'({bus.rsp_rdata, bus.rsp_err}), 64'({32'hDEAD_DEAD, 1'b0}));
      check("rstwr_addr", 64'(bus.m_axi_awaddr), 64'(0));
      @(negedge clk);
      reset  = 1'b0;
      s_no_b = 1'b0;
      seen   = 1'b0;
      repeat (4) begin
         @(negedge clk);
         seen = seen | (|bus.rsp_valid);
      end
      check("rstwr_no_rsp", 64'(seen), 64'(0));
      set_req(0, 1'b0, 32'h0000_0020, 32'h0);
      set_req(1, 1'b0, 32'h0000_0010, 32'h0);
      pair_grant(0, 32'h55AA_55AA, 2'b01, "post_rst0");
      pair_grant(1, 32'hCAFE_F00D, 2'b11, "post_rst1");

`ifdef AXI_ARB_TIMEOUT_EN
      // Slave never accepts AR: abort after TIMEOUT_CYCLES in RD.
      s_no_ar = 1'b1;
      begin
         int g, cyc;
         bit ok;
         set_req(1, 1'b0, 32'h0000_0010, 32'h0);
         wait_grant("tmo", g, ok);
         bus.req_valid = 2'b00;
         if (ok) begin
            wait_rsp("tmo", cyc, ok);
            if (ok) begin
               check("tmo_cycles", 64'(cyc), 64'(16));
               check("tmo_rsp_valid", 64'(bus.rsp_valid), 64'(2'b10));
               check("tmo_rdata_err", 64'({bus.rsp_rdata, bus.rsp_err}), 64'({32'hDEAD_DEAD, 1'b1}));
               check("tmo_arvalid", 64'({bus.m_axi_arvalid, bus.m_axi_rready}), 64'(0));
            end
         end
      end
      s_no_ar = 1'b0;
      @(negedge clk);
      do_txn(0, 1'b0, 32'h0000_0003, 32'h0, 32'h1234_5678, 1'b0, "tmo_next");
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule
